// File: rtl/move_queue.sv
// Parses 4-word coordinated-step messages into a show-ahead move FIFO; entry visible 1 cycle after last word.
// Backpressure via move_ready pop; a complete move arriving at a full FIFO with no pop is dropped and flagged.
`ifndef CMD_COORDINATED_STEP
`define CMD_COORDINATED_STEP 8'h01
`endif

module move_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] HDR_MOVE = `CMD_COORDINATED_STEP
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       word_valid,
  input  logic [63:0]                word_data,
  input  logic [63:0]                encoder_count,
  output logic [63:0]                word_reply,
  input  logic                       halt,
  output logic                       move_valid,
  input  logic                       move_ready,
  output logic                       move_dir,
  output logic [63:0]                move_duration,
  output logic signed [63:0]         move_increment,
  output logic signed [63:0]         move_incrincr,
  output logic                       buffer_dtr,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DUR, INC, INCINC} state_t;

  typedef struct packed {
    logic        dir;
    logic [63:0] dur;
    logic [63:0] inc;
    logic [63:0] incinc;
  } move_t;

  state_t        state_q, state_d;
  logic          push, pop, full, do_push, drop;
  logic          dir_q;
  logic [63:0]   dur_q, inc_q, snap_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  move_t         mem [DEPTH];
  move_t         head;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (word_valid) begin
      case (state_q)
        IDLE:    if (word_data[63:56] == HDR_MOVE) state_d = DUR;
        DUR:     state_d = INC;
        INC:     state_d = INCINC;
        INCINC: begin
          state_d = IDLE;
          push    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn)   state_q <= IDLE;
    else if (halt) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Field latches carry no control meaning, so they only need the word strobe.
  always_ff @(posedge CLK) begin
    if (word_valid) begin
      case (state_q)
        IDLE: if (word_data[63:56] == HDR_MOVE) begin
          dir_q  <= word_data[0];
          snap_q <= encoder_count;
        end
        DUR:     dur_q <= word_data;
        INC:     inc_q <= word_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetn)         word_reply <= '0;
    else if (halt)       word_reply <= '0;
    else if (word_valid) word_reply <= (state_q == INC) ? snap_q : '0;
  end

  assign full    = (fill_count == FULL_CNT);
  assign pop     = move_valid & move_ready;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge CLK) begin
    if (resetn && !halt && do_push)
      mem[wr_ptr] <= '{dir: dir_q, dur: dur_q, inc: inc_q, incinc: word_data};
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      overflow   <= 1'b0;
    end else if (halt) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (drop)    overflow <= 1'b1;
      if (do_push) wr_ptr   <= wr_ptr + AW'(1);
      if (pop)     rd_ptr   <= rd_ptr + AW'(1);
      if (do_push && !pop)      fill_count <= fill_count + CW'(1);
      else if (pop && !do_push) fill_count <= fill_count - CW'(1);
    end
  end

  // Head fields are forced to zero when empty so stale RAM never leaks out.
  assign head           = mem[rd_ptr];
  assign move_valid     = (fill_count != '0);
  assign buffer_dtr     = (fill_count < FULL_CNT);
  assign move_dir       = move_valid & head.dir;
  assign move_duration  = move_valid ? head.dur : '0;
  assign move_increment = move_valid ? head.inc : '0;
  assign move_incrincr  = move_valid ? head.incinc : '0;

endmodule

// File: tb/tb_move_queue.sv
// Randomized and directed checks of move_queue against a queue-based message/FIFO model.
module tb_move_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int OW    = CW + 260;
  localparam logic [7:0] HDR = 8'h01;

  logic               CLK = 1'b0;
  logic               resetn = 1'b0;
  logic               word_valid = 1'b0;
  logic [63:0]        word_data = '0;
  logic [63:0]        encoder_count = '0;
  logic [63:0]        word_reply;
  logic               halt = 1'b0;
  logic               move_valid;
  logic               move_ready = 1'b0;
  logic               move_dir;
  logic [63:0]        move_duration;
  logic signed [63:0] move_increment;
  logic signed [63:0] move_incrincr;
  logic               buffer_dtr;
  logic [CW-1:0]      fill_count;
  logic               overflow;

  int vecs = 0;
  int errs = 0;

  move_queue #(.DEPTH(DEPTH), .HDR_MOVE(HDR)) dut (
    .CLK(CLK), .resetn(resetn), .word_valid(word_valid), .word_data(word_data),
    .encoder_count(encoder_count), .word_reply(word_reply), .halt(halt),
    .move_valid(move_valid), .move_ready(move_ready), .move_dir(move_dir),
    .move_duration(move_duration), .move_increment(move_increment),
    .move_incrincr(move_incrincr), .buffer_dtr(buffer_dtr),
    .fill_count(fill_count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model: messages are collected whole, queue holds completed moves.
  typedef struct {
    logic        dir;
    logic [63:0] dur;
    logic [63:0] inc;
    logic [63:0] ii;
  } mv_t;

  mv_t         mq[$];
  logic [63:0] msg[$];
  logic [63:0] m_snap  = '0;
  logic [63:0] m_reply = '0;
  logic        m_ovf   = 1'b0;

  // Apply current inputs for one clock, advance the model, return at the next falling edge.
  task automatic cyc();
    mv_t e;
    if (!resetn) begin
      mq.delete(); msg.delete(); m_ovf = 1'b0; m_reply = '0;
    end else if (halt) begin
      mq.delete(); msg.delete(); m_reply = '0;
    end else begin
      if (mq.size() != 0 && move_ready) mq.delete(0);
      if (word_valid) begin
        if (msg.size() != 0 || word_data[63:56] == HDR) begin
          if (msg.size() == 0) m_snap = encoder_count;
          msg.push_back(word_data);
        end
        m_reply = (msg.size() == 3) ? m_snap : 64'd0;
        if (msg.size() == 4) begin
          e.dir = msg[0][0]; e.dur = msg[1]; e.inc = msg[2]; e.ii = msg[3];
          if (mq.size() < DEPTH) mq.push_back(e);
          else m_ovf = 1'b1;
          msg.delete();
        end
      end
    end
    @(negedge CLK);
  endtask

  function automatic logic [OW-1:0] obs();
    return {move_valid, fill_count, buffer_dtr, overflow, word_reply,
            move_dir, move_duration, move_increment, move_incrincr};
  endfunction

  function automatic logic [OW-1:0] exp_obs();
    logic [CW-1:0] n;
    logic          dtr;
    n   = CW'(mq.size());
    dtr = (mq.size() < DEPTH);
    if (mq.size() != 0)
      return {1'b1, n, dtr, m_ovf, m_reply, mq[0].dir, mq[0].dur, mq[0].inc, mq[0].ii};
    return {1'b0, n, dtr, m_ovf, m_reply, 1'b0, 192'd0};
  endfunction

  task automatic word(input logic [63:0] d, input logic [63:0] enc);
    word_valid = 1'b1; word_data = d; encoder_count = enc;
    cyc();
    word_valid = 1'b0;
  endtask

  function automatic logic [63:0] hdr_word(input logic dir);
    return {HDR, 55'd0, dir};
  endfunction

  task automatic send_move(input logic dir, input logic [63:0] dur, input logic [63:0] inc,
                           input logic [63:0] ii);
    word(hdr_word(dir), 64'd0);
    word(dur, 64'd0);
    word(inc, 64'd0);
    word(ii, 64'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; halt = 1'b1; move_ready = 1'b1;
    cyc();
    resetn = 1'b1; halt = 1'b0; move_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", move_valid); end
    vecs++; if (buffer_dtr !== 1'b1) begin errs++; $display("FAIL reset_dtr: got %b want 1", buffer_dtr); end
    vecs++; if (fill_count !== 3'd0) begin errs++; $display("FAIL reset_fill: got %0d want 0", fill_count); end
    vecs++; if ({overflow, word_reply, move_dir, move_duration, move_increment, move_incrincr} !== '0) begin
      errs++; $display("FAIL reset_zero: got ovf=%b reply=%h dur=%h", overflow, word_reply, move_duration);
    end
  endtask

  task automatic test_basic();
    do_reset();
    word(hdr_word(1'b1), 64'd0);
    word(64'd100, 64'd0);
    word(64'd5, 64'd0);
    vecs++; if (move_valid !== 1'b0) begin errs++; $display("FAIL basic_early: got valid %b want 0", move_valid); end
    word(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    vecs++; if (move_valid !== 1'b1 || fill_count !== 3'd1) begin
      errs++; $display("FAIL basic_valid: got valid=%b fill=%0d want 1/1", move_valid, fill_count);
    end
    vecs++; if ({move_dir, move_duration, move_increment, move_incrincr} !==
                {1'b1, 64'd100, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      errs++; $display("FAIL basic_fields: got dir=%b dur=%0d inc=%0d ii=%0d want 1/100/5/-1",
                       move_dir, move_duration, move_increment, move_incrincr);
    end
  endtask

  task automatic test_reply();
    logic [63:0] want [4];
    logic [63:0] enc  [4];
    logic [63:0] wd   [4];
    want = '{64'd0, 64'd0, 64'h1234, 64'd0};
    enc  = '{64'h1234, 64'hFFFF_0000, 64'hFFFF_0000, 64'hFFFF_0000};
    wd   = '{hdr_word(1'b0), 64'd7, 64'd8, 64'd9};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      word(wd[i], enc[i]);
      vecs++; if (word_reply !== want[i]) begin
        errs++; $display("FAIL reply_w%0d: got %h want %h", i, word_reply, want[i]);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) send_move(1'b0, 64'(10 + i), 64'd1, 64'd2);
    vecs++; if (overflow !== 1'b0 || fill_count !== 3'd4) begin
      errs++; $display("FAIL ovf_at_full: got ovf=%b fill=%0d want 0/4", overflow, fill_count);
    end
    send_move(1'b1, 64'd99, 64'd1, 64'd2);
    vecs++; if (fill_count !== 3'd4 || buffer_dtr !== 1'b0 || overflow !== 1'b1) begin
      errs++; $display("FAIL ovf_drop: got fill=%0d dtr=%b ovf=%b want 4/0/1", fill_count, buffer_dtr, overflow);
    end
    vecs++; if (move_duration !== 64'd10 || move_dir !== 1'b0) begin
      errs++; $display("FAIL ovf_head: got dur=%0d dir=%b want 10/0", move_duration, move_dir);
    end
    halt = 1'b1; cyc(); halt = 1'b0;
    vecs++; if (overflow !== 1'b1 || fill_count !== 3'd0) begin
      errs++; $display("FAIL ovf_halt: got ovf=%b fill=%0d want 1/0", overflow, fill_count);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) send_move(1'b0, 64'(20 + i), 64'd3, 64'd4);
    word(hdr_word(1'b1), 64'd0);
    word(64'd55, 64'd0);
    word(64'd6, 64'd0);
    move_ready = 1'b1;
    word(64'd7, 64'd0);
    move_ready = 1'b0;
    vecs++; if (fill_count !== 3'd4 || overflow !== 1'b0) begin
      errs++; $display("FAIL fullpop_cnt: got fill=%0d ovf=%b want 4/0", fill_count, overflow);
    end
    vecs++; if (move_duration !== 64'd21) begin
      errs++; $display("FAIL fullpop_head: got dur=%0d want 21", move_duration);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) send_move(1'b0, 64'(30 + i), 64'd1, 64'd1);
    word(hdr_word(1'b0), 64'd0);
    word(64'd77, 64'd0);
    halt = 1'b1; move_ready = 1'b1; word_valid = 1'b1; word_data = 64'd88;
    cyc();
    halt = 1'b0; move_ready = 1'b0; word_valid = 1'b0;
    vecs++; if (fill_count !== 3'd0 || move_valid !== 1'b0 || word_reply !== 64'd0) begin
      errs++; $display("FAIL halt_flush: got fill=%0d valid=%b reply=%h want 0/0/0", fill_count, move_valid, word_reply);
    end
    send_move(1'b1, 64'd44, 64'd2, 64'd3);
    vecs++; if (fill_count !== 3'd1 || move_duration !== 64'd44 || move_dir !== 1'b1) begin
      errs++; $display("FAIL halt_after: got fill=%0d dur=%0d dir=%b want 1/44/1", fill_count, move_duration, move_dir);
    end
  endtask

  task automatic test_bad_header();
    do_reset();
    word({8'h0A, 56'd0}, 64'd0);
    word(64'd100, 64'd0);
    word(64'd5, 64'd0);
    word(hdr_word(1'b1), 64'd0);
    vecs++; if (fill_count !== 3'd0) begin
      errs++; $display("FAIL badhdr_nopush: got fill=%0d want 0", fill_count);
    end
    word(64'd61, 64'd0);
    word(64'd62, 64'd0);
    word(64'd63, 64'd0);
    vecs++; if (fill_count !== 3'd1 || move_duration !== 64'd61 || move_dir !== 1'b1) begin
      errs++; $display("FAIL badhdr_resync: got fill=%0d dur=%0d dir=%b want 1/61/1", fill_count, move_duration, move_dir);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    word(hdr_word(1'b0), 64'd0);
    word(64'd12, 64'd0);
    do_reset();
    send_move(1'b0, 64'd13, 64'd14, 64'd15);
    vecs++; if (fill_count !== 3'd1 || move_duration !== 64'd13 || move_increment !== 64'sd14) begin
      errs++; $display("FAIL rstmid: got fill=%0d dur=%0d inc=%0d want 1/13/14", fill_count, move_duration, move_increment);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] got, want;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      resetn        = ($urandom_range(0, 299) != 0);
      halt          = ($urandom_range(0, 59) == 0);
      move_ready    = ($urandom_range(0, 2) == 0);
      word_valid    = ($urandom_range(0, 4) < 3);
      encoder_count = {$urandom, $urandom};
      word_data     = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) word_data[63:56] = HDR;
      cyc();
      got  = obs();
      want = exp_obs();
      vecs++; if (got !== want) begin
        errs++; $display("FAIL rand_c%0d: got %h want %h", c, got, want);
      end
    end
    resetn = 1'b1; halt = 1'b0; move_ready = 1'b0; word_valid = 1'b0;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_basic();
    test_reply();
    test_overflow();
    test_full_pop();
    test_halt();
    test_bad_header();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
